// File: rtl/darkquad_chan_sel_accum.sv
// darkquad_chan_sel_accum
//   Picks one channel out of a time-multiplexed sample stream and sums
//   2^ACC_LOG2 consecutive frames of it. Each sum goes out through a
//   2-entry valid/ready buffer. Channel select and enable come from a
//   software register. They are only sampled on the frame-start sample,
//   so a single sum never mixes two channels.
// Ports
//   user_clk, user_rst_n : clock, async active-low reset
//   ch_bin_reg           : [NCH_W-1:0] chan, [30] ovfl_clr, [31] enable
//   din_vld/din_sync/din : sample stream; din_sync marks channel 0
//   dout/dout_ch/dout_vld/dout_rdy : accumulated result handshake
//   ovfl                 : sticky, a result was dropped on a full buffer
//   frame_err            : 1-cycle pulse, sync seen at the wrong position
module darkquad_chan_sel_accum #(
  parameter int NCH_W    = 9,
  parameter int DW       = 16,
  parameter int ACC_LOG2 = 2
) (
  input  logic                          user_clk,
  input  logic                          user_rst_n,
  input  logic [31:0]                   ch_bin_reg,
  input  logic                          din_vld,
  input  logic                          din_sync,
  input  logic signed [DW-1:0]          din,
  output logic signed [DW+ACC_LOG2-1:0] dout,
  output logic [NCH_W-1:0]              dout_ch,
  output logic                          dout_vld,
  input  logic                          dout_rdy,
  output logic                          ovfl,
  output logic                          frame_err
);

  localparam int OW = DW + ACC_LOG2;
  localparam logic [NCH_W-1:0]    CNT_MAX = '1;
  localparam logic [ACC_LOG2-1:0] N_LAST  = '1;

  typedef enum logic {UNLOCKED, LOCKED} state_t;

  state_t                state;
  logic [NCH_W-1:0]      cnt;
  logic [NCH_W-1:0]      act_chan;
  logic                  act_en;
  logic signed [OW-1:0]  acc;
  logic [ACC_LOG2-1:0]   n;

  // second buffer entry; the first entry is the output register itself
  logic signed [OW-1:0]  b_d;
  logic [NCH_W-1:0]      b_ch;
  logic                  b_vld;

  logic                  sof, locked, realign, cfg_chg, acc_clr, hit, push, pop, drop;
  logic [NCH_W-1:0]      cnt_cur, reg_chan, chan_eff;
  logic                  reg_en, en_eff;
  logic signed [OW-1:0]  acc_base, sum;
  logic [ACC_LOG2-1:0]   n_base;

  logic unused_reg_bits;
  assign unused_reg_bits = ^ch_bin_reg[29:NCH_W];

  always_comb begin
    sof      = din_vld & din_sync;
    locked   = (state == LOCKED);
    reg_chan = ch_bin_reg[NCH_W-1:0];
    reg_en   = ch_bin_reg[31];
    // position of the current sample within the frame
    cnt_cur  = sof ? '0 : cnt + NCH_W'(1);
    // the shadow load on a sync sample already governs that sample
    chan_eff = sof ? reg_chan : act_chan;
    en_eff   = sof ? reg_en   : act_en;
    realign  = locked & sof & (cnt != CNT_MAX);
    cfg_chg  = sof & ((reg_chan != act_chan) | (reg_en != act_en));
    acc_clr  = realign | cfg_chg;
    acc_base = acc_clr ? '0 : acc;
    n_base   = acc_clr ? '0 : n;
    hit      = locked & en_eff & din_vld & (cnt_cur == chan_eff);
    sum      = acc_base + {{ACC_LOG2{din[DW-1]}}, din};
    push     = hit & (n_base == N_LAST);
    pop      = dout_vld & dout_rdy;
    drop     = push & dout_vld & b_vld & ~pop;
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state     <= UNLOCKED;
      cnt       <= '0;
      act_chan  <= '0;
      act_en    <= 1'b0;
      acc       <= '0;
      n         <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= realign;
      if (sof) begin
        state    <= LOCKED;
        act_chan <= reg_chan;
        act_en   <= reg_en;
      end
      if (din_vld & (locked | sof)) cnt <= cnt_cur;
      if (hit) begin
        acc <= push ? '0 : sum;
        n   <= push ? '0 : n_base + ACC_LOG2'(1);
      end else if (acc_clr) begin
        acc <= '0;
        n   <= '0;
      end
    end
  end

  // Output buffer: head lives in dout/dout_ch/dout_vld, so a push into an
  // empty buffer becomes visible on the very next cycle.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      dout     <= '0;
      dout_ch  <= '0;
      dout_vld <= 1'b0;
      b_d      <= '0;
      b_ch     <= '0;
      b_vld    <= 1'b0;
      ovfl     <= 1'b0;
    end else begin
      if (pop) begin
        if (b_vld) begin
          dout    <= b_d;
          dout_ch <= b_ch;
          b_vld   <= push;
          if (push) begin
            b_d  <= sum;
            b_ch <= chan_eff;
          end
        end else begin
          dout_vld <= push;
          if (push) begin
            dout    <= sum;
            dout_ch <= chan_eff;
          end
        end
      end else if (push) begin
        if (!dout_vld) begin
          dout_vld <= 1'b1;
          dout     <= sum;
          dout_ch  <= chan_eff;
        end else if (!b_vld) begin
          b_vld <= 1'b1;
          b_d   <= sum;
          b_ch  <= chan_eff;
        end
      end
      // clear has priority over a same-cycle drop
      ovfl <= ch_bin_reg[30] ? 1'b0 : (ovfl | drop);
    end
  end

endmodule

// File: tb/tb_darkquad_chan_sel_accum.sv
// Randomized scoreboard bench for darkquad_chan_sel_accum.
// A frame-level reference model predicts each sum. A monitor compares the
// sums and the status outputs on the falling edge.
module tb_darkquad_chan_sel_accum;
  logic                user_clk = 1'b0;
  logic                user_rst_n = 1'b0;
  logic [31:0]         ch_bin_reg = '0;
  logic                din_vld = 1'b0;
  logic                din_sync = 1'b0;
  logic signed [15:0]  din = '0;
  logic signed [17:0]  dout;
  logic [8:0]          dout_ch;
  logic                dout_vld;
  logic                dout_rdy = 1'b1;
  logic                ovfl;
  logic                frame_err;

  darkquad_chan_sel_accum dut (
    .user_clk(user_clk), .user_rst_n(user_rst_n), .ch_bin_reg(ch_bin_reg),
    .din_vld(din_vld), .din_sync(din_sync), .din(din),
    .dout(dout), .dout_ch(dout_ch), .dout_vld(dout_vld), .dout_rdy(dout_rdy),
    .ovfl(ovfl), .frame_err(frame_err)
  );

  always #5 user_clk = ~user_clk;

  typedef struct { int d; int ch; } res_t;
  res_t exp_q[$];

  int checks = 0;
  int errors = 0;
  bit gap_en = 1'b1;
  bit rdy_rand = 1'b0;
  int last_d = 0, last_ch = -1, ferr_seen = 0;

  // reference model state
  bit       m_locked, m_en, m_ovfl, m_ferr;
  int       m_idx, m_acc, m_n, m_occ;
  bit [8:0] m_ch;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(bit en, int ch);
    logic [31:0] r;
    r = '0;
    r[31] = en;
    r[8:0] = 9'(ch);
    return r;
  endfunction

  task automatic model_loop();
    bit pop, emit, drop;
    int dv, res;
    res_t e;
    forever begin
      @(posedge user_clk or negedge user_rst_n);
      if (!user_rst_n) begin
        m_locked = 0; m_en = 0; m_ch = '0; m_idx = 0; m_acc = 0; m_n = 0;
        m_occ = 0; m_ovfl = 0; m_ferr = 0;
        exp_q.delete();
      end else begin
        pop  = (m_occ > 0) && dout_rdy;
        emit = 0;
        res  = 0;
        m_ferr = 0;
        dv = din;
        if (din_vld) begin
          if (!m_locked) begin
            if (din_sync) begin
              m_locked = 1; m_idx = 0;
              m_ch = ch_bin_reg[8:0]; m_en = ch_bin_reg[31];
            end
          end else begin
            if (din_sync) begin
              if (m_idx != 511) begin m_ferr = 1; m_acc = 0; m_n = 0; end
              if (ch_bin_reg[8:0] != m_ch || ch_bin_reg[31] != m_en) begin m_acc = 0; m_n = 0; end
              m_ch = ch_bin_reg[8:0]; m_en = ch_bin_reg[31]; m_idx = 0;
            end else begin
              m_idx = (m_idx + 1) % 512;
            end
            if (m_en && m_idx == int'(m_ch)) begin
              m_acc += dv;
              m_n++;
              if (m_n == 4) begin emit = 1; res = m_acc; m_acc = 0; m_n = 0; end
            end
          end
        end
        drop = emit && m_occ == 2 && !pop;
        if (emit && !drop) begin
          e.d = res; e.ch = int'(m_ch);
          exp_q.push_back(e);
        end
        m_occ = m_occ - int'(pop) + int'(emit && !drop);
        m_ovfl = ch_bin_reg[30] ? 1'b0 : (m_ovfl | drop);
      end
    end
  endtask

  task automatic monitor_loop();
    res_t e;
    forever begin
      @(negedge user_clk);
      if (user_rst_n) begin
        chk("dout_vld", int'(dout_vld), int'(m_occ > 0));
        chk("frame_err", int'(frame_err), int'(m_ferr));
        chk("ovfl", int'(ovfl), int'(m_ovfl));
        if (frame_err) ferr_seen++;
        if (dout_vld && dout_rdy) begin
          chk("out_expected", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("dout", int'(dout), e.d);
            chk("dout_ch", int'(dout_ch), e.ch);
            last_d = int'(dout);
            last_ch = int'(dout_ch);
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge user_clk);
    #1;
    if (rdy_rand) dout_rdy = ($urandom_range(0, 3) != 0);
  endtask

  task automatic sample(bit sync, int val);
    while (gap_en && $urandom_range(0, 9) == 0) begin
      din_vld = 0; din_sync = 1'($urandom_range(0, 1)); din = 16'($urandom);
      tick();
    end
    din_vld = 1; din_sync = sync; din = 16'(val);
    tick();
    din_vld = 0; din_sync = 0;
  endtask

  // mode 0: din = index, 1: constant c, 2: random
  task automatic frame(int len, int mode, int c, int chg_at, logic [31:0] chg_val);
    int v;
    for (int i = 0; i < len; i++) begin
      if (i == chg_at) ch_bin_reg = chg_val;
      v = (mode == 0) ? i : (mode == 1) ? c : int'($urandom_range(0, 65535)) - 32768;
      sample(i == 0, v);
    end
  endtask

  initial begin
    int f0;
    fork
      model_loop();
      monitor_loop();
    join_none

    // reset state
    repeat (3) @(posedge user_clk);
    #1;
    chk("rst_dout_vld", int'(dout_vld), 0);
    chk("rst_dout", int'(dout), 0);
    chk("rst_dout_ch", int'(dout_ch), 0);
    chk("rst_ovfl", int'(ovfl), 0);
    chk("rst_frame_err", int'(frame_err), 0);
    user_rst_n = 1;
    ch_bin_reg = mk(1, 5);
    tick();

    // unlocked: samples without sync are ignored
    for (int i = 0; i < 20; i++) sample(0, int'($urandom_range(0, 100)));

    // 1: lock and basic sum, chan 5
    for (int f = 0; f < 4; f++) frame(512, 0, 0, -1, '0);
    repeat (3) tick();
    chk("t1_sum", last_d, 20);
    chk("t1_ch", last_ch, 5);

    // 2: chan changes to 7 mid-frame
    frame(512, 0, 0, -1, '0);
    frame(512, 0, 0, 200, mk(1, 7));
    for (int f = 0; f < 4; f++) frame(512, 0, 0, -1, '0);
    repeat (3) tick();
    chk("t2_sum", last_d, 28);
    chk("t2_ch", last_ch, 7);

    // 3: backpressure, third result dropped
    dout_rdy = 0;
    for (int f = 0; f < 12; f++) frame(512, 1, -1, -1, '0);
    repeat (3) tick();
    chk("t3_held_vld", int'(dout_vld), 1);
    chk("t3_held_val", int'(dout), -4);
    chk("t3_ovfl", int'(ovfl), 1);
    ch_bin_reg[30] = 1'b1;
    tick();
    ch_bin_reg[30] = 1'b0;
    chk("t3_ovfl_clr", int'(ovfl), 0);
    dout_rdy = 1;
    repeat (4) tick();
    chk("t3_drained", int'(dout_vld), 0);

    // 4: short frame -> frame_err, partial discarded
    f0 = ferr_seen;
    frame(512, 0, 0, -1, '0);
    frame(512, 0, 0, -1, '0);
    frame(300, 0, 0, -1, '0);
    for (int f = 0; f < 4; f++) frame(512, 0, 0, -1, '0);
    repeat (3) tick();
    chk("t4_ferr_pulses", ferr_seen - f0, 1);
    chk("t4_sum", last_d, 28);

    // 5: extremes on chan 100
    ch_bin_reg = mk(1, 100);
    for (int f = 0; f < 4; f++) frame(512, 1, -32768, -1, '0);
    repeat (3) tick();
    chk("t5_min", last_d, -131072);
    chk("t5_ch", last_ch, 100);
    for (int f = 0; f < 4; f++) frame(512, 1, 32767, -1, '0);
    repeat (3) tick();
    chk("t5_max", last_d, 131068);

    // random phase: random data, channel changes, short frames, random ready
    rdy_rand = 1;
    for (int f = 0; f < 16; f++) begin
      if ($urandom_range(0, 3) == 0)
        ch_bin_reg = mk(($urandom_range(0, 5) != 0), int'($urandom_range(0, 511)));
      ch_bin_reg[30] = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0)
        frame(512, 2, 0, int'($urandom_range(1, 511)), mk(1, int'($urandom_range(0, 511))));
      else
        frame(($urandom_range(0, 9) == 0) ? int'($urandom_range(2, 511)) : 512, 2, 0, -1, '0);
    end
    rdy_rand = 0;
    dout_rdy = 1;
    ch_bin_reg = mk(1, 100);
    repeat (6) tick();

    // 6: async reset while a result is held
    dout_rdy = 0;
    for (int f = 0; f < 5; f++) frame(512, 1, 3, -1, '0);
    repeat (2) tick();
    chk("t6_pre_vld", int'(dout_vld), 1);
    #3;
    user_rst_n = 0;
    #1;
    chk("t6_rst_vld", int'(dout_vld), 0);
    chk("t6_rst_dout", int'(dout), 0);
    repeat (2) tick();
    user_rst_n = 1;
    dout_rdy = 1;
    tick();
    for (int i = 0; i < 150; i++) sample(0, 9);
    chk("t6_ignored", int'(dout_vld), 0);
    for (int f = 0; f < 4; f++) frame(512, 1, 2, -1, '0);
    repeat (3) tick();
    chk("t6_relock_sum", last_d, 8);

    // drain anything left, bounded
    dout_rdy = 1;
    for (int i = 0; i < 50 && exp_q.size() > 0; i++) tick();
    chk("drain_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
